// File: rtl/fwd_scoreboard_if.sv
// Signals between the D stage and the forwarding scoreboard: issue tag,
// per-stage results, per-port read requests and the forwarded operands.
interface fwd_scoreboard_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NSTG = 3,
    parameter int TW   = 2
);
    localparam int SW = $clog2(NSTG + 1);

    logic                iss_valid;
    logic [AW-1:0]       iss_wa;
    logic [TW-1:0]       iss_tnew;
    logic [NSTG*DW-1:0]  stg_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*TW-1:0]   rd_tuse;
    logic [NRD*DW-1:0]   rf_data;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD*SW-1:0]   fwd_sel;
    logic                stall;
    logic [31:0]         stall_cnt;

    modport master (
        output iss_valid, iss_wa, iss_tnew, stg_data, rd_addr, rd_tuse, rf_data,
        input  rd_data, fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  iss_valid, iss_wa, iss_tnew, stg_data, rd_addr, rd_tuse, rf_data,
        output rd_data, fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: tracks in-flight register writes with a Tnew
// countdown per stage and resolves forward source and stall for every read port.
module fwd_scoreboard #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NSTG = 3,
    parameter int TW   = 2
) (
    input logic             clk,
    input logic             reset,
    fwd_scoreboard_if.slave bus
);
    localparam int SW = $clog2(NSTG + 1);

    logic [NSTG-1:0]          ent_valid;
    logic [NSTG-1:0][AW-1:0]  ent_wa;
    logic [NSTG-1:0][TW-1:0]  ent_tnew;
    logic [31:0]              stall_cnt;

    logic                     stall;
    logic [NRD-1:0]           hit;
    logic [NRD-1:0][SW-1:0]   hit_sel;
    logic [NRD-1:0][TW-1:0]   hit_tnew;
    logic [NRD-1:0][DW-1:0]   hit_data;
    logic [NRD-1:0][SW-1:0]   sel;
    logic [NRD-1:0][DW-1:0]   data;

    // Walk from oldest to youngest so the youngest matching writer is the one that sticks.
    always_comb begin
        hit      = '0;
        hit_sel  = '0;
        hit_tnew = '0;
        hit_data = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (ent_valid[k] && bus.rd_addr[p*AW +: AW] != '0 &&
                    ent_wa[k] == bus.rd_addr[p*AW +: AW]) begin
                    hit[p]      = 1'b1;
                    hit_sel[p]  = SW'(k + 1);
                    hit_tnew[p] = ent_tnew[k];
                    hit_data[p] = bus.stg_data[k*DW +: DW];
                end
            end
        end
    end

    // A pending result that is not yet due falls back to the RF; a later stage re-forwards it.
    always_comb begin
        stall = 1'b0;
        sel   = '0;
        data  = '0;
        for (int p = 0; p < NRD; p++) begin
            data[p] = bus.rf_data[p*DW +: DW];
            if (hit[p]) begin
                if (hit_tnew[p] > bus.rd_tuse[p*TW +: TW]) begin
                    stall = 1'b1;
                end
                if (hit_tnew[p] == '0) begin
                    sel[p]  = hit_sel[p];
                    data[p] = hit_data[p];
                end
            end
        end
    end

    assign bus.rd_data   = data;
    assign bus.fwd_sel   = sel;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt;

    // A stalled D stage pushes a bubble into entry 0; the oldest entry retires into the RF.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            ent_wa    <= '0;
            ent_tnew  <= '0;
            stall_cnt <= '0;
        end else begin
            ent_valid[0] <= bus.iss_valid && (bus.iss_wa != '0) && !stall;
            ent_wa[0]    <= bus.iss_wa;
            ent_tnew[0]  <= bus.iss_tnew;
            for (int k = 1; k < NSTG; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wa[k]    <= ent_wa[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            end
            if (stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: a driver predicts each cycle's outputs from
// a list of issued writes and their ages; a negedge monitor pops and compares.
module tb_fwd_scoreboard;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NSTG = 3;
    localparam int TW   = 2;
    localparam int SW   = $clog2(NSTG + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.DW(DW), .AW(AW), .NRD(NRD), .NSTG(NSTG), .TW(TW)) bus ();

    fwd_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD), .NSTG(NSTG), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        int                       cyc;
        logic                     stall;
        logic [31:0]              cnt;
        logic [NRD-1:0][SW-1:0]   sel;
        logic [NRD-1:0][DW-1:0]   data;
    } exp_t;

    // One record per accepted register write, stamped with the cycle it left D.
    typedef struct {
        int wa;
        int tnew;
        int cyc;
    } wr_t;

    exp_t        expq[$];
    wr_t         inflight[$];
    exp_t        mon_e;
    int          cyc   = 0;
    logic [31:0] mcnt  = '0;
    int          total = 0;
    int          bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checkOutput($sformatf("c%0d stall", mon_e.cyc), 64'(bus.stall), 64'(mon_e.stall));
            checkOutput($sformatf("c%0d stall_cnt", mon_e.cyc), 64'(bus.stall_cnt), 64'(mon_e.cnt));
            for (int p = 0; p < NRD; p++) begin
                checkOutput($sformatf("c%0d fwd_sel[%0d]", mon_e.cyc, p),
                            64'(bus.fwd_sel[p*SW +: SW]), 64'(mon_e.sel[p]));
                checkOutput($sformatf("c%0d rd_data[%0d]", mon_e.cyc, p),
                            64'(bus.rd_data[p*DW +: DW]), 64'(mon_e.data[p]));
            end
        end
    end

    // Drives one cycle, predicts its outputs and advances the reference model.
    task automatic applyStimulus(input logic iv, input int wa, input int tnew,
                                 input int a0, input int t0, input int a1, input int t1,
                                 input logic rst, input logic preload);
        int          addr[NRD];
        int          tuse[NRD];
        logic [DW-1:0] stg[NSTG];
        logic [DW-1:0] rf[NRD];
        exp_t        e;
        int          best;
        int          rem;
        int          age;

        @(posedge clk);
        #1;
        if (preload) begin
            force dut.stall_cnt = 32'hFFFF_FFFE;
            #1;
            release dut.stall_cnt;
            mcnt = 32'hFFFF_FFFE;
        end

        addr[0] = a0;
        addr[1] = a1;
        tuse[0] = t0;
        tuse[1] = t1;
        for (int k = 0; k < NSTG; k++) stg[k] = $urandom;
        for (int p = 0; p < NRD; p++) rf[p] = $urandom;

        reset         = rst;
        bus.iss_valid = iv;
        bus.iss_wa    = AW'(wa);
        bus.iss_tnew  = TW'(tnew);
        for (int k = 0; k < NSTG; k++) bus.stg_data[k*DW +: DW] = stg[k];
        for (int p = 0; p < NRD; p++) begin
            bus.rf_data[p*DW +: DW] = rf[p];
            bus.rd_addr[p*AW +: AW] = AW'(addr[p]);
            bus.rd_tuse[p*TW +: TW] = TW'(tuse[p]);
        end

        e.cyc   = cyc;
        e.stall = 1'b0;
        e.cnt   = mcnt;
        for (int p = 0; p < NRD; p++) begin
            e.sel[p]  = '0;
            e.data[p] = rf[p];
            best = -1;
            rem  = 0;
            if (addr[p] != 0) begin
                foreach (inflight[i]) begin
                    age = cyc - inflight[i].cyc - 1;
                    if (age >= 0 && age < NSTG && inflight[i].wa == addr[p] && (best < 0 || age < best)) begin
                        best = age;
                        rem  = (inflight[i].tnew > age) ? inflight[i].tnew - age : 0;
                    end
                end
            end
            if (best >= 0) begin
                if (rem > tuse[p]) e.stall = 1'b1;
                if (rem == 0) begin
                    e.sel[p]  = SW'(best + 1);
                    e.data[p] = stg[best];
                end
            end
        end
        expq.push_back(e);

        if (rst) begin
            inflight.delete();
            mcnt = '0;
        end else begin
            if (e.stall && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
            if (iv && wa != 0 && !e.stall) inflight.push_back('{wa, tnew, cyc});
        end
        cyc++;
        while (inflight.size() > 0 && cyc - inflight[0].cyc - 1 >= NSTG) void'(inflight.pop_front());
    endtask

    function automatic int pickAddr();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 3;
            2:       return 5;
            3:       return 8;
            4:       return 9;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.iss_valid = 1'b0;
        bus.iss_wa    = '0;
        bus.iss_tnew  = '0;
        bus.stg_data  = '0;
        bus.rd_addr   = '0;
        bus.rd_tuse   = '0;
        bus.rf_data   = '0;
        repeat (2) @(posedge clk);

        $display("[TB] idle reads after reset");
        repeat (10) applyStimulus(0, 0, 0, 5, 0, 0, 0, 0, 0);

        $display("[TB] ALU result forwarded from E then M");
        applyStimulus(1, 8, 0, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 8, 0, 0, 0, 0, 0);

        $display("[TB] load-use stall");
        applyStimulus(1, 3, 2, 0, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 3, 0, 0, 0, 0, 0);

        $display("[TB] back-to-back writers and register 0 read");
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 0, 9, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 9, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 9, 0, 9, 0, 0, 0);

        $display("[TB] load with tuse=1");
        applyStimulus(1, 4, 2, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 4, 1, 0, 0, 0, 0);

        $display("[TB] writes to register 0 are never tracked");
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset while stalled");
        applyStimulus(1, 3, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 3, 0, 3, 0, 1, 0);
        applyStimulus(0, 0, 0, 3, 0, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 3, 0, 3, 0, 0, 0);

        $display("[TB] stall counter saturation");
        applyStimulus(1, 7, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 7, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(0, 0, 0, 7, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)), pickAddr(), int'($urandom_range(0, 3)),
                          pickAddr(), int'($urandom_range(0, 3)),
                          pickAddr(), int'($urandom_range(0, 3)),
                          logic'($urandom_range(0, 49) == 0), 0);
        end

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
